// File: rtl/b16_dbg_pkg.sv
// Shared constants and types for the b16 debug unit: register map, bit positions,
// breakpoint mode bits and the run-control state encoding.
package b16_dbg_pkg;

  localparam logic [4:0] IDX_CTRL    = 5'd8;
  localparam logic [4:0] IDX_STEPCNT = 5'd9;
  localparam logic [4:0] IDX_STATUS  = 5'd10;
  localparam logic [4:0] IDX_BP_BASE = 5'd16;

  localparam int CTRL_GO    = 0;
  localparam int CTRL_COUNT = 1;

  localparam int STAT_STEPDONE = 14;
  localparam int STAT_DRUN     = 15;

  localparam int BPCFG_FETCH = 0;
  localparam int BPCFG_RD    = 1;
  localparam int BPCFG_WR    = 2;
  localparam int BPCFG_K_LSB = 8;
  localparam int BPCFG_K_MSB = 11;

  typedef struct packed {
    logic wr;
    logic rd;
    logic fetch;
  } bp_mode_t;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } run_state_t;

endpackage

// File: rtl/b16_debug_unit_if.sv
// Host bus seen by the debug unit: halfword address, write data, strobes and
// combinational read data.
interface b16_dbg_host_if #(
  parameter int L = 16
) ();
  logic [L-1:1] addr;
  logic [L-1:0] wdata;
  logic         r;
  logic [1:0]   w;
  logic [L-1:0] rdata;

  modport master (output addr, output wdata, output r, output w, input rdata);
  modport slave  (input addr, input wdata, input r, input w, output rdata);
endinterface

// File: rtl/b16_bp_match.sv
// One breakpoint/watchpoint comparator: mode qualification plus masked address
// compare. Purely combinational; the caller qualifies with drun.
module b16_bp_match
  import b16_dbg_pkg::*;
#(
  parameter int L = 16
) (
  input  logic [L-1:0] i_bpaddr,
  input  bp_mode_t     i_mode,
  input  logic [3:0]   i_k,
  input  logic [L-1:0] i_cpu_addr,
  input  logic         i_cpu_r,
  input  logic [1:0]   i_cpu_w,
  input  logic         i_cpu_fetch,
  output logic         o_match
);

  logic [L-1:0] w_mask;
  logic         w_mode_hit;

  always_comb begin
    // K low address bits are don't-care
    w_mask     = '1 << i_k;
    w_mode_hit = (i_mode.fetch & i_cpu_fetch & i_cpu_r)
               | (i_mode.rd & i_cpu_r & ~i_cpu_fetch)
               | (i_mode.wr & (|i_cpu_w));
    o_match    = w_mode_hit & (((i_cpu_addr ^ i_bpaddr) & w_mask) == '0);
  end

endmodule

// File: rtl/b16_debug_unit.sv
// b16 debug unit: register window, breakpoint channels, step down-counter and
// run control for the core's run input.
//   state   | meaning
//   ST_HALT | core stopped (drun=0), debug port forwarding enabled
//   ST_RUN  | free running until a breakpoint hit
//   ST_STEP | running while the step down-counter is non-terminal
module b16_debug_unit
  import b16_dbg_pkg::*;
#(
  parameter int           L       = 16,
  parameter int           NBP     = 4,
  parameter logic [L-7:0] DBGADDR = 10'h3FF
) (
  input  logic            clk,
  input  logic            reset,
  b16_dbg_host_if.slave   bus,
  input  logic [L-1:0]    cpu_addr,
  input  logic            cpu_r,
  input  logic [1:0]      cpu_w,
  input  logic            cpu_fetch,
  output logic            drun,
  output logic            dr,
  output logic            dw,
  output logic [2:0]      daddr
);

  logic           w_sel, w_rd, w_wr, w_ctrl_wr, w_stat_wr, w_tc, w_expire;
  logic [4:0]     w_idx;
  logic [L-1:0]   r_stepcnt, r_cnt, w_cnt_nxt;
  logic [NBP-1:0] r_hit, w_match, w_hit, w_hit_clr;
  logic           r_stepdone;
  logic [L-1:0]   r_bpaddr [NBP];
  bp_mode_t       r_bpmode [NBP];
  logic [3:0]     r_bpk    [NBP];
  run_state_t     r_state, w_state_nxt;

  assign w_sel     = (bus.addr[L-1:6] == DBGADDR);
  assign w_idx     = bus.addr[5:1];
  assign w_rd      = w_sel & bus.r;
  assign w_wr      = w_sel & (|bus.w);
  assign w_ctrl_wr = w_wr & (w_idx == IDX_CTRL);
  assign w_stat_wr = w_wr & (w_idx == IDX_STATUS);

  assign drun  = (r_state != ST_HALT);
  assign dr    = w_rd & ~bus.addr[5] & ~bus.addr[4] & ~drun;
  assign dw    = w_wr & ~bus.addr[5] & ~bus.addr[4] & ~drun;
  assign daddr = bus.addr[3:1];

  for (genvar gi = 0; gi < NBP; gi++) begin : g_bp
    b16_bp_match #(.L(L)) u_match (
      .i_bpaddr    (r_bpaddr[gi]),
      .i_mode      (r_bpmode[gi]),
      .i_k         (r_bpk[gi]),
      .i_cpu_addr  (cpu_addr),
      .i_cpu_r     (cpu_r),
      .i_cpu_w     (cpu_w),
      .i_cpu_fetch (cpu_fetch),
      .o_match     (w_match[gi])
    );
  end

  assign w_hit     = w_match & {NBP{drun}};
  assign w_hit_clr = w_stat_wr ? bus.wdata[NBP-1:0] : '0;

  // Priority: host CTRL write, then hit / step expiry, then counting
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_tc        = (r_state == ST_STEP) && (r_cnt == L'(1));
    w_expire    = w_tc && !w_ctrl_wr;
    if (w_ctrl_wr) begin
      if (!bus.wdata[CTRL_GO]) begin
        w_state_nxt = ST_HALT;
      end else if (bus.wdata[CTRL_COUNT]) begin
        w_state_nxt = ST_STEP;
        w_cnt_nxt   = (r_stepcnt == '0) ? L'(1) : r_stepcnt;
      end else begin
        w_state_nxt = ST_RUN;
      end
    end else if ((|w_hit) || w_tc) begin
      w_state_nxt = ST_HALT;
    end else if (r_state == ST_STEP) begin
      w_cnt_nxt = r_cnt - L'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_stepcnt  <= '0;
      r_hit      <= '0;
      r_stepdone <= 1'b0;
      for (int i = 0; i < NBP; i++) begin
        r_bpaddr[i] <= '1;
        r_bpmode[i] <= '0;
        r_bpk[i]    <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hit      <= (r_hit & ~w_hit_clr) | w_hit;
      r_stepdone <= (r_stepdone & ~(w_stat_wr & bus.wdata[STAT_STEPDONE])) | w_expire;
      if (w_wr && (w_idx == IDX_STEPCNT)) r_stepcnt <= bus.wdata;
      for (int i = 0; i < NBP; i++) begin
        if (w_wr && (w_idx == IDX_BP_BASE + 5'(2 * i))) begin
          r_bpaddr[i] <= bus.wdata;
        end
        if (w_wr && (w_idx == IDX_BP_BASE + 5'(2 * i + 1))) begin
          r_bpmode[i] <= bp_mode_t'(bus.wdata[BPCFG_WR:BPCFG_FETCH]);
          r_bpk[i]    <= bus.wdata[BPCFG_K_MSB:BPCFG_K_LSB];
        end
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (w_rd) begin
      if (w_idx == IDX_STEPCNT) begin
        bus.rdata = r_stepcnt;
      end else if (w_idx == IDX_STATUS) begin
        bus.rdata[NBP-1:0]     = r_hit;
        bus.rdata[STAT_STEPDONE] = r_stepdone;
        bus.rdata[STAT_DRUN]     = drun;
      end else begin
        for (int i = 0; i < NBP; i++) begin
          if (w_idx == IDX_BP_BASE + 5'(2 * i)) bus.rdata = r_bpaddr[i];
          if (w_idx == IDX_BP_BASE + 5'(2 * i + 1)) begin
            bus.rdata[BPCFG_WR:BPCFG_FETCH]     = r_bpmode[i];
            bus.rdata[BPCFG_K_MSB:BPCFG_K_LSB] = r_bpk[i];
          end
        end
      end
    end
  end

endmodule
